hypot_sched: RTL and testbench

HYPOT_SCHED -- requirements
Module: hypot_sched

---
 rtl/hypot_sched.sv | 152 +++++++++++++++
 tb/tb_hypot_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hypot_sched.sv
// Two-requester hypotenuse engine: arbitrates between two operand pairs and
// returns floor(sqrt(x*x + y*y)) through a multi-cycle square/root sequencer.
module hypot_sched #(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_x,
  input  logic [7:0] req0_y,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_x,
  input  logic [7:0] req1_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [8:0] rsp_data,
  output logic       rsp_id,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQX  = 3'd1,
    SQY  = 3'd2,
    ROOT = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_last;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic        r_id;
  logic [16:0] r_sum;
  logic [8:0]  r_root;
  logic [3:0]  r_bit;
  logic        r_rsp_valid;
  logic [8:0]  r_rsp_data;
  logic        r_rsp_id;

  logic        w_idle;
  logic        w_grant;
  logic        w_accept;
  logic [8:0]  w_trial;
  logic [17:0] w_trial_sq;
  logic        w_fits;

  assign w_idle = (r_state == IDLE);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = RR ? ~r_last : 1'b0;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  // Readys are masked during reset so every output is quiet while rst is high.
  assign req0_ready = w_idle & ~rst & req0_valid & ~w_grant;
  assign req1_ready = w_idle & ~rst & req1_valid &  w_grant;
  assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // One restoring-root step: keep the trial bit if its square still fits.
  assign w_trial    = r_root | (9'd1 << r_bit);
  assign w_trial_sq = {9'd0, w_trial} * {9'd0, w_trial};
  assign w_fits     = (w_trial_sq <= {1'b0, r_sum});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SQX;
      SQX:     w_next = SQY;
      SQY:     w_next = ROOT;
      ROOT:    if (r_bit == 4'd0) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: all datapath registers are reset here; there are no memories, so
  // clearing everything is cheap and makes an aborted operation leave no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= 1'b1;
      r_x         <= 8'd0;
      r_y         <= 8'd0;
      r_id        <= 1'b0;
      r_sum       <= 17'd0;
      r_root      <= 9'd0;
      r_bit       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 9'd0;
      r_rsp_id    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x    <= w_grant ? req1_x : req0_x;
            r_y    <= w_grant ? req1_y : req0_y;
            r_id   <= w_grant;
            r_last <= w_grant;
          end
        end
        SQX: begin
          r_sum <= {9'd0, r_x} * {9'd0, r_x};
        end
        SQY: begin
          r_sum  <= r_sum + ({9'd0, r_y} * {9'd0, r_y});
          r_root <= 9'd0;
          r_bit  <= 4'd8;
        end
        ROOT: begin
          if (w_fits) r_root <= w_trial;
          r_bit <= r_bit - 4'd1;
          // Final step publishes the finished root directly into the response.
          if (r_bit == 4'd0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_fits ? w_trial : r_root;
            r_rsp_id    <= r_id;
          end
        end
        RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = ~w_idle;

endmodule

// File: tb/tb_hypot_sched.sv
// Directed bench for hypot_sched: latency, corner operands, arbitration in
// both modes, response backpressure and reset abort.
module tb_hypot_sched;

  logic       clk = 1'b0;
  logic       rst;

  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_x, req0_y, req1_x, req1_y;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [8:0] rsp_data;

  logic       f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
  logic [7:0] f_req0_x, f_req0_y, f_req1_x, f_req1_y;
  logic       f_rsp_valid, f_rsp_ready, f_rsp_id, f_busy;
  logic [8:0] f_rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hypot_sched #(.RR(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy)
  );

  hypot_sched #(.RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_x(f_req0_x), .req0_y(f_req0_y),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_x(f_req1_x), .req1_y(f_req1_y),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data), .rsp_id(f_rsp_id),
    .busy(f_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Single request on the RR instance with rsp_ready held high.
  task automatic do_req(input logic id, input logic [7:0] x, input logic [7:0] y,
                        input logic [8:0] exp, input string tag);
    int n;
    if (!id) begin
      req0_x = x; req0_y = y; req0_valid = 1'b1;
    end else begin
      req1_x = x; req1_y = y; req1_valid = 1'b1;
    end
    #1;
    check({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    check({tag, "_other_ready"}, id ? req0_ready : req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    n = 0;
    while (!rsp_valid && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 11);
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_id"}, rsp_id, id);
    tick();
    check({tag, "_valid_drop"}, rsp_valid, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_data_hold"}, rsp_data, exp);
  endtask

  initial begin
    int n;
    int cnt;
    logic [3:0] ids;
    logic [3:0] exp_rr;

    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = 8'd0; req0_y = 8'd0; req1_x = 8'd0; req1_y = 8'd0;
    f_rsp_ready = 1'b1;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    f_req0_x = 8'd0; f_req0_y = 8'd0; f_req1_x = 8'd0; f_req1_y = 8'd0;
    tick();
    tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    do_req(1'b0, 8'd3, 8'd4, 9'd5, "basic_3_4");
    do_req(1'b0, 8'd0, 8'd0, 9'd0, "corner_0_0");
    do_req(1'b0, 8'd1, 8'd1, 9'd1, "corner_1_1");
    do_req(1'b0, 8'd255, 8'd255, 9'd360, "corner_255_255");
    do_req(1'b0, 8'd255, 8'd0, 9'd255, "corner_255_0");
    do_req(1'b1, 8'd6, 8'd8, 9'd10, "lone_req1");

    // Backpressure: hold the response for five cycles with both requesters waiting.
    rsp_ready = 1'b0;
    req1_x = 8'd5; req1_y = 8'd12; req1_valid = 1'b1;
    #1;
    check("stall_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 30) begin
      tick();
      n++;
    end
    check("stall_latency", n, 11);
    req0_x = 8'd9; req0_y = 8'd9; req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, 13);
      check("stall_id", rsp_id, 1);
      check("stall_busy", busy, 1);
      check("stall_ready0", req0_ready, 0);
      check("stall_ready1_low", req1_ready, 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("release_valid", rsp_valid, 0);
    check("release_idle", busy, 0);
    check("release_data_hold", rsp_data, 13);
    check("release_id_hold", rsp_id, 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid) cnt++;
    end
    check("release_single_rsp", cnt, 0);

    // Reset in the middle of ROOT aborts the operation.
    req0_x = 8'd255; req0_y = 8'd255; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    repeat (5) tick();
    check("abort_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_data", rsp_data, 0);
    check("abort_rsp_id", rsp_id, 0);
    check("abort_busy", busy, 0);
    tick();
    tick();
    check("abort_hold_valid", rsp_valid, 0);
    rst = 1'b0;
    do_req(1'b0, 8'd6, 8'd8, 9'd10, "post_rst");

    // Round-robin with both requesters continuously valid.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_x = 8'd3; req0_y = 8'd4; req0_valid = 1'b1;
    req1_x = 8'd6; req1_y = 8'd8; req1_valid = 1'b1;
    #1;
    check("rr_tie_ready0", req0_ready, 1);
    check("rr_tie_ready1", req1_ready, 0);
    exp_rr = 4'b1010;
    ids = 4'd0;
    cnt = 0;
    n = 0;
    while (cnt < 4 && n < 200) begin
      tick();
      n++;
      if (rsp_valid) begin
        ids[cnt] = rsp_id;
        check("rr_data", rsp_data, rsp_id ? 10 : 5);
        cnt++;
      end
    end
    check("rr_count", cnt, 4);
    check("rr_id_seq", ids, exp_rr);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Fixed priority: requester 1 never wins while requester 0 stays valid.
    f_req0_x = 8'd3; f_req0_y = 8'd4; f_req0_valid = 1'b1;
    f_req1_x = 8'd6; f_req1_y = 8'd8; f_req1_valid = 1'b1;
    #1;
    check("fp_tie_ready0", f_req0_ready, 1);
    check("fp_tie_ready1", f_req1_ready, 0);
    ids = 4'b1111;
    cnt = 0;
    n = 0;
    while (cnt < 4 && n < 200) begin
      tick();
      n++;
      if (f_rsp_valid) begin
        ids[cnt] = f_rsp_id;
        check("fp_data", f_rsp_data, 5);
        cnt++;
      end
    end
    check("fp_count", cnt, 4);
    check("fp_id_seq", ids, 0);
    f_req0_valid = 1'b0;
    f_req1_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
